// File: rtl/ring_host_pkg.sv
// ring_host_pkg: shared definitions for the ring host interface.
//   - default widths for ring indices and host register addresses
//   - host register byte offsets
//   - writeback FSM state and round-robin grant encodings
package ring_host_pkg;

  localparam int C_IDX_BITS_DEFAULT  = 12;
  localparam int C_ADDR_BITS_DEFAULT = 6;

  // Host register byte offsets
  localparam int unsigned REG_CTRL          = 'h00;
  localparam int unsigned REG_IRQ_STAT      = 'h04;
  localparam int unsigned REG_INB_BASE      = 'h10;
  localparam int unsigned REG_INB_CONS_ADDR = 'h14;
  localparam int unsigned REG_INB_PROD_IDX  = 'h18;
  localparam int unsigned REG_INB_CONS_IDX  = 'h1C;
  localparam int unsigned REG_OUT_BASE      = 'h20;
  localparam int unsigned REG_OUT_PROD_ADDR = 'h24;
  localparam int unsigned REG_OUT_CONS_IDX  = 'h28;
  localparam int unsigned REG_OUT_PROD_IDX  = 'h2C;
  localparam int unsigned REG_IRQ_EN        = 'h30;
  localparam int unsigned REG_COALESCE      = 'h34;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_IN  = 2'd1,
    WB_OUT = 2'd2
  } wb_state_e;

  // Which ring was served last; reset value (OUT) makes a tie right after
  // reset go to the inband ring first.
  typedef enum logic {
    GRANT_OUT = 1'b0,
    GRANT_IN  = 1'b1
  } grant_e;

endpackage

// File: rtl/ring_host_if_if.sv
// ring_host_if_if: single-beat memory writeback bus.
//   wb_req  : request valid, driven by the master
//   wb_addr : 32-bit writeback address
//   wb_data : 32-bit writeback data (zero-extended ring index)
//   wb_ack  : request accepted, driven by the slave
// Handshake: the master raises wb_req with wb_addr/wb_data and holds all
// three stable until it samples wb_ack=1 on a rising edge; that edge
// completes the transfer and wb_req is low the following cycle. wb_ack is
// only meaningful while wb_req=1.
interface ring_host_if_if;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;

  modport master (output wb_req, output wb_addr, output wb_data, input wb_ack);
  modport slave  (input wb_req, input wb_addr, input wb_data, output wb_ack);
endinterface

// File: rtl/ring_wb_arb.sv
// ring_wb_arb: firmware index change detection and writeback sequencing.
// Ports:
//   sys_clk, sys_rst_n      clock, synchronous active-low reset
//   ring_enable             detection and new writebacks only while 1
//   inband_cons_index       firmware inband consumer index
//   outband_prod_index      firmware outband producer index
//   inband_cons_addr        writeback address for the inband index
//   outband_prod_addr       writeback address for the outband index
//   wb                      writeback bus (master side)
//   out_acked               pulse: an outband writeback is acked this cycle
//   state                   FSM state, for debug
module ring_wb_arb
  import ring_host_pkg::*;
#(
  parameter int C_IDX_BITS = C_IDX_BITS_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  ring_enable,
  input  logic [C_IDX_BITS-1:0] inband_cons_index,
  input  logic [C_IDX_BITS-1:0] outband_prod_index,
  input  logic [31:0]           inband_cons_addr,
  input  logic [31:0]           outband_prod_addr,
  ring_host_if_if.master        wb,
  output logic                  out_acked,
  output wb_state_e             state
);

  logic                  in_dirty;
  logic                  out_dirty;
  logic [C_IDX_BITS-1:0] last_in;
  logic [C_IDX_BITS-1:0] last_out;
  grant_e                last_grant;

  assign out_acked = (state == WB_OUT) && wb.wb_ack;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      in_dirty    <= 1'b0;
      out_dirty   <= 1'b0;
      last_in     <= '0;
      last_out    <= '0;
      last_grant  <= GRANT_OUT;
      wb.wb_req   <= 1'b0;
      wb.wb_addr  <= '0;
      wb.wb_data  <= '0;
    end else begin
      // Change detection. While disabled the shadows follow the inputs so
      // enabling the ring does not replay stale changes.
      if (ring_enable) begin
        if (inband_cons_index != last_in)   in_dirty  <= 1'b1;
        if (outband_prod_index != last_out) out_dirty <= 1'b1;
      end else begin
        last_in   <= inband_cons_index;
        last_out  <= outband_prod_index;
        in_dirty  <= 1'b0;
        out_dirty <= 1'b0;
      end

      // Capture assignments below override the dirty updates above, so a
      // flag cleared at capture stays clear unless the index moves again.
      case (state)
        IDLE: begin
          if (ring_enable && in_dirty && (!out_dirty || last_grant == GRANT_OUT)) begin
            last_in    <= inband_cons_index;
            in_dirty   <= 1'b0;
            wb.wb_data <= 32'(inband_cons_index);
            wb.wb_addr <= inband_cons_addr;
            wb.wb_req  <= 1'b1;
            last_grant <= GRANT_IN;
            state      <= WB_IN;
          end else if (ring_enable && out_dirty) begin
            last_out   <= outband_prod_index;
            out_dirty  <= 1'b0;
            wb.wb_data <= 32'(outband_prod_index);
            wb.wb_addr <= outband_prod_addr;
            wb.wb_req  <= 1'b1;
            last_grant <= GRANT_OUT;
            state      <= WB_OUT;
          end
        end
        WB_IN, WB_OUT: begin
          // Finishes even if ring_enable dropped meanwhile.
          if (wb.wb_ack) begin
            wb.wb_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          wb.wb_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ring_host_if.sv
// ring_host_if: host-side ring configuration and index writeback block.
// Holds the ring configuration registers and the inband doorbell, writes
// firmware index updates back to host memory and raises host_irq on
// outband progress.
// Optional feature macro: RING_HOST_COALESCE_EN (interrupt coalescing via
// register 0x34).
// Ports:
//   sys_clk, sys_rst_n                clock, synchronous active-low reset
//   host_wr/host_addr/host_wdata      single-cycle register write
//   host_rdata                        combinational read of host_addr
//   ring_enable                       ring enable to the bridge
//   inband_base, inband_cons_addr     inband ring base / cons writeback addr
//   inband_prod_index                 host doorbell
//   inband_cons_index                 firmware inband consumer index
//   outband_base, outband_prod_addr   outband ring base / prod writeback addr
//   outband_cons_index                host outband consumer index
//   outband_prod_index                firmware outband producer index
//   wb                                writeback bus (master)
//   host_irq                          level interrupt
//   dbg_state                         writeback FSM state, for debug
module ring_host_if
  import ring_host_pkg::*;
#(
  parameter int C_IDX_BITS  = C_IDX_BITS_DEFAULT,
  parameter int C_ADDR_BITS = C_ADDR_BITS_DEFAULT
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   host_wr,
  input  logic [C_ADDR_BITS-1:0] host_addr,
  input  logic [31:0]            host_wdata,
  output logic [31:0]            host_rdata,
  output logic                   ring_enable,
  output logic [31:0]            inband_base,
  output logic [31:0]            inband_cons_addr,
  output logic [C_IDX_BITS-1:0]  inband_prod_index,
  input  logic [C_IDX_BITS-1:0]  inband_cons_index,
  output logic [31:0]            outband_base,
  output logic [31:0]            outband_prod_addr,
  output logic [C_IDX_BITS-1:0]  outband_cons_index,
  input  logic [C_IDX_BITS-1:0]  outband_prod_index,
  ring_host_if_if.master         wb,
  output logic                   host_irq,
  output wb_state_e              dbg_state
);

  localparam logic [C_ADDR_BITS-1:0] A_CTRL          = C_ADDR_BITS'(REG_CTRL);
  localparam logic [C_ADDR_BITS-1:0] A_IRQ_STAT      = C_ADDR_BITS'(REG_IRQ_STAT);
  localparam logic [C_ADDR_BITS-1:0] A_INB_BASE      = C_ADDR_BITS'(REG_INB_BASE);
  localparam logic [C_ADDR_BITS-1:0] A_INB_CONS_ADDR = C_ADDR_BITS'(REG_INB_CONS_ADDR);
  localparam logic [C_ADDR_BITS-1:0] A_INB_PROD_IDX  = C_ADDR_BITS'(REG_INB_PROD_IDX);
  localparam logic [C_ADDR_BITS-1:0] A_INB_CONS_IDX  = C_ADDR_BITS'(REG_INB_CONS_IDX);
  localparam logic [C_ADDR_BITS-1:0] A_OUT_BASE      = C_ADDR_BITS'(REG_OUT_BASE);
  localparam logic [C_ADDR_BITS-1:0] A_OUT_PROD_ADDR = C_ADDR_BITS'(REG_OUT_PROD_ADDR);
  localparam logic [C_ADDR_BITS-1:0] A_OUT_CONS_IDX  = C_ADDR_BITS'(REG_OUT_CONS_IDX);
  localparam logic [C_ADDR_BITS-1:0] A_OUT_PROD_IDX  = C_ADDR_BITS'(REG_OUT_PROD_IDX);
  localparam logic [C_ADDR_BITS-1:0] A_IRQ_EN        = C_ADDR_BITS'(REG_IRQ_EN);
`ifdef RING_HOST_COALESCE_EN
  localparam logic [C_ADDR_BITS-1:0] A_COALESCE      = C_ADDR_BITS'(REG_COALESCE);
`endif

  logic irq_pending;
  logic irq_en;
  logic out_acked;
  logic w1c;
  logic pend_set;

  assign w1c = host_wr && (host_addr == A_IRQ_STAT) && host_wdata[0];

`ifdef RING_HOST_COALESCE_EN
  logic [7:0] coal_count;
  logic [7:0] coal_acks;
  logic [7:0] coal_next;

  // Saturating count of outband acks since the last W1C.
  assign coal_next = (coal_acks == 8'hFF) ? 8'hFF : coal_acks + 8'd1;
  assign pend_set  = out_acked && ((coal_count == 8'd0) || (coal_next >= coal_count));
`else
  assign pend_set  = out_acked;
`endif

  ring_wb_arb #(
    .C_IDX_BITS (C_IDX_BITS)
  ) u_arb (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .ring_enable        (ring_enable),
    .inband_cons_index  (inband_cons_index),
    .outband_prod_index (outband_prod_index),
    .inband_cons_addr   (inband_cons_addr),
    .outband_prod_addr  (outband_prod_addr),
    .wb                 (wb),
    .out_acked          (out_acked),
    .state              (dbg_state)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ring_enable        <= 1'b0;
      inband_base        <= '0;
      inband_cons_addr   <= '0;
      inband_prod_index  <= '0;
      outband_base       <= '0;
      outband_prod_addr  <= '0;
      outband_cons_index <= '0;
      irq_en             <= 1'b0;
      irq_pending        <= 1'b0;
      host_irq           <= 1'b0;
`ifdef RING_HOST_COALESCE_EN
      coal_count         <= '0;
      coal_acks          <= '0;
`endif
    end else begin
      if (host_wr) begin
        case (host_addr)
          A_CTRL:          ring_enable        <= host_wdata[0];
          A_INB_BASE:      inband_base        <= host_wdata;
          A_INB_CONS_ADDR: inband_cons_addr   <= host_wdata;
          A_INB_PROD_IDX:  inband_prod_index  <= host_wdata[C_IDX_BITS-1:0];
          A_OUT_BASE:      outband_base       <= host_wdata;
          A_OUT_PROD_ADDR: outband_prod_addr  <= host_wdata;
          A_OUT_CONS_IDX:  outband_cons_index <= host_wdata[C_IDX_BITS-1:0];
          A_IRQ_EN:        irq_en             <= host_wdata[0];
`ifdef RING_HOST_COALESCE_EN
          A_COALESCE:      coal_count         <= host_wdata[7:0];
`endif
          default: ;
        endcase
      end

      // A set in the same cycle as a W1C wins.
      irq_pending <= pend_set | (irq_pending & ~w1c);
      host_irq    <= irq_pending & irq_en;

`ifdef RING_HOST_COALESCE_EN
      if (w1c)            coal_acks <= out_acked ? 8'd1 : 8'd0;
      else if (out_acked) coal_acks <= coal_next;
`endif
    end
  end

  always_comb begin
    host_rdata = '0;
    case (host_addr)
      A_CTRL:          host_rdata = {31'd0, ring_enable};
      A_IRQ_STAT:      host_rdata = {31'd0, irq_pending};
      A_INB_BASE:      host_rdata = inband_base;
      A_INB_CONS_ADDR: host_rdata = inband_cons_addr;
      A_INB_PROD_IDX:  host_rdata = 32'(inband_prod_index);
      A_INB_CONS_IDX:  host_rdata = 32'(inband_cons_index);
      A_OUT_BASE:      host_rdata = outband_base;
      A_OUT_PROD_ADDR: host_rdata = outband_prod_addr;
      A_OUT_CONS_IDX:  host_rdata = 32'(outband_cons_index);
      A_OUT_PROD_IDX:  host_rdata = 32'(outband_prod_index);
      A_IRQ_EN:        host_rdata = {31'd0, irq_en};
`ifdef RING_HOST_COALESCE_EN
      A_COALESCE:      host_rdata = {24'd0, coal_count};
`endif
      default:         host_rdata = '0;
    endcase
  end

endmodule
